ibex_csr_rmw_ctrl: RTL and testbench
====================================

# ibex_csr_rmw_ctrl

Access sequencer driving one control/status register primitive (the write-data/write-enable/read-data/read-error port of a CSR body). It accepts read, write, set and clear requests from the CSR decode stage, performs the read-modify-write, re-reads the register to verify the update, and reports integrity failures. The block is the initiator-side counterpart of the CSR storage primitive and sits between the CSR decoder and each shadowed CSR.

## Interface
- Width, 32: CSR data width.
- WriteMask, '1 (Width bits): writable bits; bits at 0 always keep their current value.
- LockOnError, 1'b1: when set, a raised alert blocks all further writes until cleared.

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  1  request valid; accepted when req_i && ready_o
- op_i  in  2  2'b00 READ, 2'b01 WRITE, 2'b10 SET, 2'b11 CLEAR
- wdata_i  in  Width  operand
- ready_o  out  1  high only in IDLE
- rvalid_o  out  1  one-cycle response strobe
- rdata_o  out  Width  CSR value read before modification
- err_o  out  1  response error, valid with rvalid_o
- alert_o  out  1  sticky integrity alert
- alert_clr_i  in  1  clears alert_o
- csr_wr_data_o  out  Width  data to CSR primitive
- csr_wr_en_o  out  1  write enable to CSR primitive
- csr_rd_data_i  in  Width  registered CSR value
- csr_rd_error_i  in  1  CSR shadow mismatch

## Operation
- States: IDLE, READ, WRITE, VERIFY, RESP.
- IDLE: ready_o=1. On req_i, capture op_i and wdata_i into op_q/wdata_q; go to READ.
- READ: sample old_q <= csr_rd_data_i. If csr_rd_error_i: set alert, err_q=1, go to RESP (no write). Else compute new = WRITE: wdata_q; SET: old|wdata_q; CLEAR: old&~wdata_q; then exp = (new & WriteMask) | (old & ~WriteMask); store exp_q.
- Write decision in READ: op READ -> no write; SET/CLEAR with (wdata_q & WriteMask)==0 -> no write; WRITE -> always write. No write -> RESP with err_q=0.
- Lock: if LockOnError && alert_o and a write is required -> no write, err_q=1, go to RESP.
- WRITE: csr_wr_en_o=1, csr_wr_data_o=exp_q for exactly one cycle; go to VERIFY.
- VERIFY: if csr_rd_error_i or csr_rd_data_i != exp_q: set alert, err_q=1. Go to RESP.
- RESP: rvalid_o=1, rdata_o=old_q, err_o=err_q; go to IDLE.
- Alert: set by READ/VERIFY failures; cleared by alert_clr_i; set wins when both in same cycle.
- csr_wr_data_o is exp_q in all states (0 after reset); only csr_wr_en_o qualifies it.

## Timing
- Reset: state IDLE, ready_o=1, rvalid_o=0, err_o=0, rdata_o=0, alert_o=0, csr_wr_en_o=0, csr_wr_data_o=0, all internal registers 0.
- Accept at cycle T; READ at T+1; write path: WRITE (csr_wr_en_o) at T+2, VERIFY at T+3, rvalid_o at T+4. No-write/error/lock path: rvalid_o at T+2.
- Next request accepted earliest the cycle after RESP (throughput 1 per 3 or 5 cycles).
- req_i ignored while ready_o=0; no queueing.
- csr_rd_data_i sampled in VERIFY reflects the write of T+2 (primitive updates on the edge ending WRITE).
- rst_ni assertion mid-operation: immediately IDLE, csr_wr_en_o drops asynchronously, no response issued, alert cleared.
- rdata_o and err_o hold their value after RESP until the next RESP.

## Test plan
- Reset, then WRITE wdata=32'hDEAD_BEEF with CSR=0, WriteMask='1 -> csr_wr_en_o high at T+2 with 32'hDEAD_BEEF, rvalid_o at T+4, rdata_o=0, err_o=0.
- WriteMask=32'h0000_FFFF, CSR=32'h1234_0000, SET wdata=32'hFFFF_00FF -> written value 32'h1234_00FF, rdata_o=32'h1234_0000; CLEAR wdata=32'hFF00_0000 -> no write, rvalid_o at T+2.
- READ with csr_rd_error_i=1 in READ -> no csr_wr_en_o, rvalid_o at T+2, err_o=1, alert_o=1; subsequent WRITE -> no write, err_o=1 (lock).
- Model forces csr_rd_data_i=32'h0 in VERIFY after WRITE 32'h5 -> err_o=1, alert_o=1; alert_clr_i same cycle as failure -> alert_o stays 1; later alert_clr_i alone -> 0.
- Back-to-back requests with req_i held high -> second accepted only the cycle after first rvalid_o; ready_o low T+1..T+4.
- rst_ni low during WRITE -> csr_wr_en_o=0 immediately, no rvalid_o, ready_o=1 after release.

Source files
------------

// File: rtl/ibex_csr_rmw_ctrl.sv
// Read-modify-write sequencer for a single CSR primitive: read, update under mask,
// re-read to verify, and raise a sticky integrity alert on any mismatch.
module ibex_csr_rmw_ctrl #(
    parameter int unsigned      Width       = 32,
    parameter logic [Width-1:0] WriteMask   = '1,
    parameter bit               LockOnError = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic [1:0]       op_i,
    input  logic [Width-1:0] wdata_i,
    output logic             ready_o,
    output logic             rvalid_o,
    output logic [Width-1:0] rdata_o,
    output logic             err_o,
    output logic             alert_o,
    input  logic             alert_clr_i,
    output logic [Width-1:0] csr_wr_data_o,
    output logic             csr_wr_en_o,
    input  logic [Width-1:0] csr_rd_data_i,
    input  logic             csr_rd_error_i
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StVerify,
        StResp
    } state_e;

    typedef enum logic [1:0] {
        OpRead  = 2'b00,
        OpWrite = 2'b01,
        OpSet   = 2'b10,
        OpClear = 2'b11
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q;
    logic [Width-1:0] wdata_q;
    logic [Width-1:0] old_q;
    logic [Width-1:0] exp_q;
    logic             err_q;
    logic             alert_q;
    logic [Width-1:0] rdata_q;
    logic             rerr_q;

    logic [Width-1:0] new_val;
    logic [Width-1:0] exp_val;
    logic             need_write;
    logic             lock_hit;
    logic             verify_fail;
    logic             alert_set;

    // Modified value; read-only bits are merged back from the current CSR value.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        new_val = csr_rd_data_i;
        unique case (op_q)
            OpWrite: new_val = wdata_q;
            OpSet:   new_val = csr_rd_data_i | wdata_q;
            OpClear: new_val = csr_rd_data_i & ~wdata_q;
            default: new_val = csr_rd_data_i;
        endcase
    end

    assign exp_val     = (new_val & WriteMask) | (csr_rd_data_i & ~WriteMask);
    assign need_write  = (op_q == OpWrite) ||
                         (((op_q == OpSet) || (op_q == OpClear)) && |(wdata_q & WriteMask));
    assign lock_hit    = LockOnError && alert_q && need_write;
    assign verify_fail = csr_rd_error_i || (csr_rd_data_i != exp_q);
    assign alert_set   = ((state_q == StRead) && csr_rd_error_i) ||
                         ((state_q == StVerify) && verify_fail);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req_i) state_d = StRead;
            StRead:   state_d = (csr_rd_error_i || lock_hit || !need_write) ? StResp : StWrite;
            StWrite:  state_d = StVerify;
            StVerify: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q    <= OpRead;
            wdata_q <= '0;
            old_q   <= '0;
            exp_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_i) begin
                        op_q    <= op_e'(op_i);
                        wdata_q <= wdata_i;
                        err_q   <= 1'b0;
                    end
                end
                StRead: begin
                    old_q <= csr_rd_data_i;
                    err_q <= csr_rd_error_i || lock_hit;
                    if (!csr_rd_error_i) exp_q <= exp_val;
                end
                StVerify: begin
                    if (verify_fail) err_q <= 1'b1;
                end
                StResp: begin
                    rdata_q <= old_q;
                    rerr_q  <= err_q;
                end
                default: ;
            endcase
        end
    end

    // A failure in the same cycle as a clear request keeps the alert raised.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alert_q <= 1'b0;
        end else if (alert_set) begin
            alert_q <= 1'b1;
        end else if (alert_clr_i) begin
            alert_q <= 1'b0;
        end
    end

    // Responses are presented live in RESP and held afterwards until the next one.
    always_comb begin
        ready_o       = (state_q == StIdle);
        rvalid_o      = (state_q == StResp);
        csr_wr_en_o   = (state_q == StWrite);
        csr_wr_data_o = exp_q;
        rdata_o       = (state_q == StResp) ? old_q : rdata_q;
        err_o         = (state_q == StResp) ? err_q : rerr_q;
        alert_o       = alert_q;
    end

endmodule

// File: tb/tb_ibex_csr_rmw_ctrl.sv
// Randomized bench for ibex_csr_rmw_ctrl: two instances (full and half write mask),
// each attached to a behavioural CSR primitive, checked against a transaction-level model.
module tb_ibex_csr_rmw_ctrl;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic        clk_i = 1'b0;
    logic        rst_ni;

    logic        req        [2];
    logic [1:0]  op_s       [2];
    logic [31:0] wdata_s    [2];
    logic        alert_clr  [2];
    logic        rd_err     [2];
    logic        force_zero [2];
    logic        preload_en [2];
    logic [31:0] preload_val[2];
    logic [31:0] csr_mem    [2];
    logic [31:0] rd_data    [2];

    logic        ready  [2];
    logic        rvalid [2];
    logic [31:0] rdata  [2];
    logic        err    [2];
    logic        alert  [2];
    logic [31:0] wr_data[2];
    logic        wr_en  [2];

    logic [31:0] model_csr  [2];
    bit          model_alert[2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        ibex_csr_rmw_ctrl #(
            .Width      (32),
            .WriteMask  ((g == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF),
            .LockOnError(1'b1)
        ) u_dut (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .req_i         (req[g]),
            .op_i          (op_s[g]),
            .wdata_i       (wdata_s[g]),
            .ready_o       (ready[g]),
            .rvalid_o      (rvalid[g]),
            .rdata_o       (rdata[g]),
            .err_o         (err[g]),
            .alert_o       (alert[g]),
            .alert_clr_i   (alert_clr[g]),
            .csr_wr_data_o (wr_data[g]),
            .csr_wr_en_o   (wr_en[g]),
            .csr_rd_data_i (rd_data[g]),
            .csr_rd_error_i(rd_err[g])
        );

        // CSR primitive: registered value, updated on the edge that ends a write cycle.
        always @(posedge clk_i) begin
            if (preload_en[g])  csr_mem[g] <= preload_val[g];
            else if (wr_en[g])  csr_mem[g] <= wr_data[g];
        end
        assign rd_data[g] = force_zero[g] ? 32'h0 : csr_mem[g];
    end

    function automatic logic [31:0] mask_of(input int i);
        return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic set_csr(input int i, input logic [31:0] v);
        @(negedge clk_i);
        preload_en[i]  = 1'b1;
        preload_val[i] = v;
        @(negedge clk_i);
        preload_en[i]  = 1'b0;
        model_csr[i]   = v;
    endtask

    task automatic clear_alert(input int i);
        @(negedge clk_i);
        alert_clr[i] = 1'b1;
        @(negedge clk_i);
        alert_clr[i]   = 1'b0;
        model_alert[i] = 1'b0;
        check("alert_cleared", {31'h0, alert[i]}, 32'h0);
    endtask

    // One transaction, started at a negedge with the instance idle.
    // inj_rd: CSR reports an error during READ; inj_vz: CSR reads back zero during VERIFY;
    // clr_fail: alert clear requested in the VERIFY cycle.
    task automatic do_txn(input int i, input logic [1:0] op, input logic [31:0] w,
                          input bit inj_rd, input bit inj_vz, input bit clr_fail);
        logic [31:0] m, old, nw, expv, wr_val, rd_val;
        bit need_wr, exp_wr, exp_err, fail, clr_applied;
        int exp_lat, wr_cyc, rv_cyc;
        logic er_val;

        m   = mask_of(i);
        old = model_csr[i];
        case (op)
            OP_WRITE: nw = w;
            OP_SET:   nw = old | w;
            OP_CLEAR: nw = old & ~w;
            default:  nw = old;
        endcase
        expv    = (nw & m) | (old & ~m);
        need_wr = (op == OP_WRITE) || ((op == OP_SET || op == OP_CLEAR) && ((w & m) != 0));
        exp_wr  = 1'b0;
        exp_err = 1'b0;
        fail    = 1'b0;
        if (inj_rd) begin
            exp_err = 1'b1;
            fail    = 1'b1;
        end else if (need_wr && model_alert[i]) begin
            exp_err = 1'b1;
        end else if (need_wr) begin
            exp_wr = 1'b1;
            if (inj_vz && expv != 32'h0) begin
                exp_err = 1'b1;
                fail    = 1'b1;
            end
        end
        exp_lat     = exp_wr ? 4 : 2;
        clr_applied = exp_wr && inj_vz && clr_fail;

        check("ready_idle", {31'h0, ready[i]}, 32'h1);
        req[i]     = 1'b1;
        op_s[i]    = op;
        wdata_s[i] = w;
        @(negedge clk_i);
        req[i]    = 1'b0;
        rd_err[i] = inj_rd;
        check("ready_busy", {31'h0, ready[i]}, 32'h0);

        wr_cyc = -1;
        rv_cyc = -1;
        wr_val = '0;
        rd_val = '0;
        er_val = 1'b0;
        for (int c = 2; c <= 8 && rv_cyc < 0; c++) begin
            @(negedge clk_i);
            rd_err[i]     = 1'b0;
            force_zero[i] = 1'b0;
            alert_clr[i]  = 1'b0;
            if (wr_en[i]) begin
                wr_cyc = c;
                wr_val = wr_data[i];
            end
            if (rvalid[i]) begin
                rv_cyc = c;
                rd_val = rdata[i];
                er_val = err[i];
            end
            if (inj_vz && wr_cyc == c - 1 && wr_cyc > 0) begin
                force_zero[i] = 1'b1;
                alert_clr[i]  = clr_fail;
            end
        end

        check("rvalid_latency", rv_cyc, exp_lat);
        check("write_cycle", wr_cyc, exp_wr ? 2 : -1);
        if (exp_wr) check("write_data", wr_val, expv);
        check("rdata", rd_val, old);
        check("err", {31'h0, er_val}, {31'h0, exp_err});

        if (fail)             model_alert[i] = 1'b1;
        else if (clr_applied) model_alert[i] = 1'b0;
        check("alert", {31'h0, alert[i]}, {31'h0, model_alert[i]});

        if (exp_wr) model_csr[i] = expv;
        @(negedge clk_i);
        check("hold_rdata", rdata[i], old);
        check("hold_err", {31'h0, err[i]}, {31'h0, exp_err});
        check("ready_after", {31'h0, ready[i]}, 32'h1);
        check("csr_value", csr_mem[i], model_csr[i]);
    endtask

    initial begin
        logic [31:0] w;
        bit seen_rv;

        rst_ni = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; op_s[i] = OP_READ; wdata_s[i] = '0; alert_clr[i] = 1'b0;
            rd_err[i] = 1'b0; force_zero[i] = 1'b0; preload_en[i] = 1'b1; preload_val[i] = '0;
            model_csr[i] = '0; model_alert[i] = 1'b0;
        end
        repeat (2) @(negedge clk_i);
        for (int i = 0; i < 2; i++) begin
            preload_en[i] = 1'b0;
            check("rst_ready", {31'h0, ready[i]}, 32'h1);
            check("rst_rvalid", {31'h0, rvalid[i]}, 32'h0);
            check("rst_err", {31'h0, err[i]}, 32'h0);
            check("rst_rdata", rdata[i], 32'h0);
            check("rst_alert", {31'h0, alert[i]}, 32'h0);
            check("rst_wr_en", {31'h0, wr_en[i]}, 32'h0);
            check("rst_wr_data", wr_data[i], 32'h0);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Directed scenarios
        do_txn(0, OP_WRITE, 32'hDEAD_BEEF, 0, 0, 0);
        check("dir_write_csr", csr_mem[0], 32'hDEAD_BEEF);
        set_csr(1, 32'h1234_0000);
        do_txn(1, OP_SET, 32'hFFFF_00FF, 0, 0, 0);
        check("dir_set_csr", csr_mem[1], 32'h1234_00FF);
        do_txn(1, OP_CLEAR, 32'hFF00_0000, 0, 0, 0);
        do_txn(0, OP_READ, 32'h0, 1, 0, 0);
        do_txn(0, OP_WRITE, 32'h0000_0042, 0, 0, 0);
        clear_alert(0);
        do_txn(0, OP_WRITE, 32'h0000_0005, 0, 1, 1);
        check("dir_alert_kept", {31'h0, alert[0]}, 32'h1);
        clear_alert(0);

        // Back-to-back with req held: accepts every 5 cycles, response 4 cycles after accept
        w = 32'hA5A5_0F0F;
        req[0] = 1'b1; op_s[0] = OP_WRITE; wdata_s[0] = w;
        for (int k = 0; k <= 10; k++) begin
            check("b2b_ready", {31'h0, ready[0]}, {31'h0, (k % 5) == 0});
            check("b2b_rvalid", {31'h0, rvalid[0]}, {31'h0, (k % 5) == 4});
            if (k == 10) req[0] = 1'b0;
            else         @(negedge clk_i);
        end
        model_csr[0] = w;
        check("b2b_csr", csr_mem[0], w);

        // Reset asserted in the middle of a WRITE cycle
        req[0] = 1'b1; op_s[0] = OP_WRITE; wdata_s[0] = 32'h0BAD_F00D;
        @(negedge clk_i);
        req[0] = 1'b0;
        @(negedge clk_i);
        check("rst_mid_wr_en_before", {31'h0, wr_en[0]}, 32'h1);
        #1 rst_ni = 1'b0;
        #1;
        check("rst_mid_wr_en", {31'h0, wr_en[0]}, 32'h0);
        check("rst_mid_ready", {31'h0, ready[0]}, 32'h1);
        model_alert[0] = 1'b0;
        model_alert[1] = 1'b0;
        @(negedge clk_i);
        check("rst_mid_csr", csr_mem[0], model_csr[0]);
        rst_ni = 1'b1;
        seen_rv = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            if (rvalid[0]) seen_rv = 1'b1;
        end
        check("rst_mid_no_rvalid", {31'h0, seen_rv}, 32'h0);
        check("rst_mid_ready_after", {31'h0, ready[0]}, 32'h1);

        // Randomized traffic on both instances
        for (int n = 0; n < 60; n++) begin
            int i;
            logic [1:0] op;
            i  = int'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       w = 32'h0;
                1:       w = $urandom & 32'hFFFF_0000;
                default: w = $urandom;
            endcase
            if (model_alert[i] && $urandom_range(0, 2) == 0) clear_alert(i);
            do_txn(i, op, w, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
